// File: rtl/jtframe_dwnld_pkg.sv
// Shared definitions for the ROM download path.
//   prog_state_t : write FSM encoding (IDLE / WRITE)
//   FIFO_DEPTH   : entries in the ioctl byte FIFO
//   FIFO_DW      : FIFO entry width, {offset[24:0], data[7:0]}
//   lane_mask    : active-low byte enable for an SDRAM 16-bit word
package jtframe_dwnld_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } prog_state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
  localparam int OFFSET_W   = 25;
  localparam int FIFO_DW    = OFFSET_W + 8;

  // Even byte offsets land in the low lane (mask 2'b10), odd ones in the
  // high lane (2'b01). swab flips the lane for byte-swapped ROM images.
  function automatic logic [1:0] lane_mask(input logic odd, input logic swab);
    return (odd ^ swab) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/jtframe_ioctl_fifo.sv
// Small show-ahead FIFO buffering ioctl bytes in front of the SDRAM writer.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push, din  : write request and entry; ignored when full unless a pop
//                happens on the same edge
//   pop        : consume the head entry; ignored when empty
//   dout       : head entry, valid whenever empty=0
//   full,empty : occupancy flags
module jtframe_ioctl_fifo
  import jtframe_dwnld_pkg::*;
#(
  parameter int DW = FIFO_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             do_pop;
  logic             do_push;

  // The extra pointer bit tells a full FIFO from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[FIFO_AW-1:0]];

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/jtframe_ioctl_prog.sv
// Converts the ioctl byte stream of a ROM download into SDRAM byte writes.
//   clk, rst_n          : clock, asynchronous active-low reset
//   downloading         : ROM download in progress
//   ioctl_addr/dout/wr  : byte address, byte data, one-cycle byte strobe
//   prog_addr/data/mask : SDRAM word address, byte, active-low lane enables
//   prog_we, prog_rdy   : level write request, held until the controller accepts
//   dwnld_busy          : download path active (extended by HOLD cycles)
//   overflow            : sticky, a byte was dropped on a full FIFO
module jtframe_ioctl_prog
  import jtframe_dwnld_pkg::*;
#(
  parameter int SDRAMW = 22,
  parameter int HEADER = 0,
  parameter int SWAB   = 0,
  parameter int HOLD   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [7:0]        prog_data,
  output logic [1:0]        prog_mask,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow
);

  localparam logic [24:0] HDR    = 25'(HEADER);
  localparam logic        SWAB_B = (SWAB != 0);
  localparam int          HW     = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_V = HW'(HOLD);

  // Reset asserts asynchronously and releases on the second clock edge.
  logic [1:0] rst_sync;
  logic       rst_li;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_li = rst_sync[1];

  prog_state_t   state;
  logic          push_req;
  logic          pop;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [32:0]   head;
  logic [24:0]   head_off;
  logic [7:0]    head_data;
  logic          unused_off;

  assign push_req = ioctl_wr & downloading & (ioctl_addr >= HDR);
  assign pop      = (state == ST_IDLE) & ~fifo_empty;
  assign drop     = push_req & fifo_full & ~pop;

  jtframe_ioctl_fifo #(.DW(FIFO_DW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_li),
    .push  (push_req),
    .din   ({ioctl_addr - HDR, ioctl_dout}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_off   = head[32:8];
  assign head_data  = head[7:0];
  // Offset bits above the word address simply wrap away.
  assign unused_off = ^head_off;

  always_ff @(posedge clk or negedge rst_li) begin
    if (!rst_li) begin
      state     <= ST_IDLE;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
      prog_we   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            prog_addr <= head_off[SDRAMW:1];
            prog_data <= head_data;
            prog_mask <= lane_mask(head_off[0], SWAB_B);
            prog_we   <= 1'b1;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (prog_rdy) begin
            prog_we <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Overflow is sticky for the whole download; a new download clears it.
  logic dl_q;

  always_ff @(posedge clk or negedge rst_li) begin
    if (!rst_li) begin
      dl_q     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl_q     <= downloading;
      overflow <= (overflow & ~(downloading & ~dl_q)) | drop;
    end
  end

  // Busy follows activity and then lingers HOLD cycles so the consumer sees
  // the SDRAM settle; any new activity reloads the tail.
  logic          active;
  logic [HW-1:0] hold_cnt;

  assign active = downloading | ~fifo_empty | (state == ST_WRITE);

  always_ff @(posedge clk or negedge rst_li) begin
    if (!rst_li)               hold_cnt <= '0;
    else if (active)           hold_cnt <= HOLD_V;
    else if (hold_cnt != '0)   hold_cnt <= hold_cnt - HW'(1);
  end

  assign dwnld_busy = rst_li & (active | (hold_cnt != '0));

endmodule

// File: tb/tb_jtframe_ioctl_prog.sv
// Directed bench for jtframe_ioctl_prog. Three instances share the stimulus:
//   u_a : defaults (HEADER=0, SDRAMW=22, SWAB=0, HOLD=16)
//   u_b : HEADER=2
//   u_c : SDRAMW=4, SWAB=1
// Inputs change 1 ns after the rising edge; outputs are sampled then or on
// the falling edge. Accepted writes are logged as {addr[21:0], mask, data}.
module tb_jtframe_ioctl_prog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic        prog_rdy;

  logic [21:0] a_addr;  logic [7:0] a_data;  logic [1:0] a_mask;
  logic        a_we, a_busy, a_ovf;
  logic [21:0] b_addr;  logic [7:0] b_data;  logic [1:0] b_mask;
  logic        b_we, b_busy, b_ovf;
  logic [3:0]  c_addr;  logic [7:0] c_data;  logic [1:0] c_mask;
  logic        c_we, c_busy, c_ovf;

  always #5 clk = ~clk;

  jtframe_ioctl_prog u_a (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .prog_addr(a_addr), .prog_data(a_data), .prog_mask(a_mask), .prog_we(a_we),
    .prog_rdy(prog_rdy), .dwnld_busy(a_busy), .overflow(a_ovf)
  );

  jtframe_ioctl_prog #(.HEADER(2)) u_b (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .prog_addr(b_addr), .prog_data(b_data), .prog_mask(b_mask), .prog_we(b_we),
    .prog_rdy(prog_rdy), .dwnld_busy(b_busy), .overflow(b_ovf)
  );

  jtframe_ioctl_prog #(.SDRAMW(4), .SWAB(1)) u_c (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .prog_addr(c_addr), .prog_data(c_data), .prog_mask(c_mask), .prog_we(c_we),
    .prog_rdy(prog_rdy), .dwnld_busy(c_busy), .overflow(c_ovf)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_acc_a = 0;
  int          gap_err  = 0;
  logic        prev_acc_a = 1'b0;
  logic [31:0] log_a[$];
  logic [31:0] log_b[$];
  logic [31:0] log_c[$];

  function automatic logic [31:0] wr(input logic [21:0] addr, input logic [1:0] mask,
                                     input logic [7:0] data);
    return {addr, mask, data};
  endfunction

  function automatic logic [31:0] a_at(input int i);
    return (i < log_a.size()) ? log_a[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] b_at(input int i);
    return (i < log_b.size()) ? log_b[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] c_at(input int i);
    return (i < log_c.size()) ? log_c[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic clear_logs();
    log_a.delete();
    log_b.delete();
    log_c.delete();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // A write is accepted on the rising edge following a falling edge that
  // sees prog_we=1 and prog_rdy=1.
  always @(negedge clk) begin
    if (a_we && prev_acc_a) gap_err <= gap_err + 1;
    prev_acc_a <= a_we && prog_rdy;
    if (a_we && prog_rdy) begin
      log_a.push_back(wr(a_addr, a_mask, a_data));
      last_acc_a <= cyc + 1;
    end
    if (b_we && prog_rdy) log_b.push_back(wr(b_addr, b_mask, b_data));
    if (c_we && prog_rdy) log_c.push_back(wr(22'(c_addr), c_mask, c_data));
  end

  initial begin
    int fall_cyc;

    rst_n       = 1'b0;
    downloading = 1'b1;
    ioctl_wr    = 1'b0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    prog_rdy    = 1'b0;

    // Reset state, with downloading already high.
    repeat (3) tick();
    check("rst_we",   32'(a_we),   32'h0);
    check("rst_mask", 32'(a_mask), 32'h3);
    check("rst_busy", 32'(a_busy), 32'h0);
    check("rst_ovf",  32'(a_ovf),  32'h0);
    check("rst_addr", 32'(a_addr), 32'h0);
    rst_n = 1'b1;
    tick();
    check("rst_release_busy", 32'(a_busy), 32'h0);
    repeat (4) tick();
    check("busy_dl", 32'(a_busy), 32'h1);

    // Two bytes, controller always ready.
    prog_rdy = 1'b1;
    clear_logs();
    send_byte(25'h0, 8'h11);
    check("lat_edge_n", 32'(a_we), 32'h0);
    send_byte(25'h1, 8'h22);
    check("lat_edge_n1", 32'(a_we), 32'h1);
    repeat (10) tick();
    check("t1_a_cnt", 32'(log_a.size()), 32'd2);
    check("t1_a0", a_at(0), wr(22'h0, 2'b10, 8'h11));
    check("t1_a1", a_at(1), wr(22'h0, 2'b01, 8'h22));
    check("t1_b_cnt", 32'(log_b.size()), 32'd0);
    check("t1_c0_swab", c_at(0), wr(22'h0, 2'b01, 8'h11));
    check("t1_c1_swab", c_at(1), wr(22'h0, 2'b10, 8'h22));
    check("t1_gap", 32'(gap_err), 32'd0);

    // Header skip: addresses 0..3 on a HEADER=2 instance.
    clear_logs();
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(8'hA0 + i));
    repeat (12) tick();
    check("t2_b_cnt", 32'(log_b.size()), 32'd2);
    check("t2_b0", b_at(0), wr(22'h0, 2'b10, 8'hA2));
    check("t2_b1", b_at(1), wr(22'h0, 2'b01, 8'hA3));
    check("t2_a_cnt", 32'(log_a.size()), 32'd4);
    check("t2_a3", a_at(3), wr(22'h1, 2'b01, 8'hA3));

    // Word address wrap on a narrow SDRAM.
    clear_logs();
    send_byte(25'h40, 8'h5A);
    send_byte(25'h23, 8'h3C);
    repeat (8) tick();
    check("t4_c0_wrap", c_at(0), wr(22'h0, 2'b01, 8'h5A));
    check("t4_c1_wrap", c_at(1), wr(22'h1, 2'b10, 8'h3C));
    check("t4_a0", a_at(0), wr(22'h20, 2'b10, 8'h5A));
    check("t4_b1", b_at(1), wr(22'h10, 2'b01, 8'h3C));

    // Overflow: controller stalled while six bytes arrive back-to-back.
    prog_rdy = 1'b0;
    clear_logs();
    for (int i = 0; i < 6; i++) send_byte(25'(32'h100 + i), 8'(8'h60 + i));
    tick();
    check("t3_ovf", 32'(a_ovf), 32'h1);
    check("t3_we_held", 32'(a_we), 32'h1);
    check("t3_addr_held", 32'(a_addr), 32'h80);
    repeat (3) tick();
    check("t3_data_stable", 32'(a_data), 32'h60);
    check("t3_b_ovf", 32'(b_ovf), 32'h1);
    prog_rdy = 1'b1;
    repeat (15) tick();
    check("t3_a_cnt", 32'(log_a.size()), 32'd5);
    check("t3_a0", a_at(0), wr(22'h80, 2'b10, 8'h60));
    check("t3_a4", a_at(4), wr(22'h82, 2'b10, 8'h64));
    downloading = 1'b0;
    tick();
    check("t3_ovf_sticky", 32'(a_ovf), 32'h1);
    downloading = 1'b1;
    tick();
    check("t3_ovf_clear", 32'(a_ovf), 32'h0);

    // Drain after downloading falls, then HOLD tail on busy.
    prog_rdy = 1'b0;
    clear_logs();
    for (int i = 0; i < 3; i++) send_byte(25'(32'h200 + i), 8'(8'h70 + i));
    downloading = 1'b0;
    repeat (3) tick();
    check("t5_busy_queued", 32'(a_busy), 32'h1);
    check("t5_none_yet", 32'(log_a.size()), 32'd0);
    prog_rdy = 1'b1;
    fall_cyc = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (!a_busy) begin
        fall_cyc = cyc;
        break;
      end
    end
    check("t5_a_cnt", 32'(log_a.size()), 32'd3);
    check("t5_a2", a_at(2), wr(22'h101, 2'b10, 8'h72));
    check("t5_hold", 32'(fall_cyc - last_acc_a), 32'd16);

    // Reset in the middle of a stalled write.
    downloading = 1'b1;
    prog_rdy    = 1'b0;
    clear_logs();
    send_byte(25'h300, 8'h80);
    send_byte(25'h301, 8'h81);
    repeat (2) tick();
    check("t6_we_before", 32'(a_we), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_we_async", 32'(a_we), 32'h0);
    check("t6_mask_async", 32'(a_mask), 32'h3);
    check("t6_busy_async", 32'(a_busy), 32'h0);
    repeat (2) tick();
    rst_n    = 1'b1;
    prog_rdy = 1'b1;
    repeat (12) tick();
    check("t6_no_writes", 32'(log_a.size()), 32'd0);
    check("t6_we_after", 32'(a_we), 32'h0);
    check("t6_busy_after", 32'(a_busy), 32'h1);
    check("gap_total", 32'(gap_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtframe_ioctl_prog.md
JTFRAME_IOCTL_PROG -- requirements
Module: jtframe_ioctl_prog

Interface
REQ-001 SHALL have parameter SDRAMW, default 22: prog_addr width in 16-bit words.
REQ-002 SHALL have parameter HEADER, default 0: count of leading download bytes to discard.
REQ-003 SHALL have parameter SWAB, default 0: 1 swaps the byte lane selected in prog_mask.
REQ-004 SHALL have parameter HOLD, default 16: busy-extension cycles after the write path drains.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port downloading, input, 1 bit: ROM download in progress.
REQ-008 SHALL have port ioctl_addr, input, 25 bits: byte address of the current ioctl byte.
REQ-009 SHALL have port ioctl_dout, input, 8 bits: ioctl data byte.
REQ-010 SHALL have port ioctl_wr, input, 1 bit: one-cycle byte strobe.
REQ-011 SHALL have port prog_addr, output, SDRAMW bits: SDRAM word address.
REQ-012 SHALL have port prog_data, output, 8 bits: byte to write.
REQ-013 SHALL have port prog_mask, output, 2 bits: active-low byte enables.
REQ-014 SHALL have port prog_we, output, 1 bit: write request, level, held until accepted.
REQ-015 SHALL have port prog_rdy, input, 1 bit: SDRAM controller accepted the write.
REQ-016 SHALL have port dwnld_busy, output, 1 bit: download path active.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag, a byte was dropped.

Function
REQ-018 A byte SHALL be pushed into a 4-entry FIFO of {offset, data} on an edge where ioctl_wr=1, downloading=1 and ioctl_addr>=HEADER; offset = ioctl_addr-HEADER.
REQ-019 Bytes with ioctl_addr<HEADER, or with downloading=0, SHALL be discarded silently.
REQ-020 A push to a full FIFO SHALL drop the byte, leave the FIFO unchanged and set overflow.
REQ-021 overflow SHALL clear only on reset or on the rising edge of downloading.
REQ-022 Simultaneous push and pop SHALL both take effect, leaving occupancy unchanged; a pop from a full FIFO in that same edge SHALL make room, so the push SHALL NOT be dropped.
REQ-023 The FSM SHALL have states IDLE and WRITE.
REQ-024 In IDLE with the FIFO non-empty, the FSM SHALL pop the FIFO head, register prog_addr=offset[SDRAMW:1] (truncated, wrapping above 2^SDRAMW words) and prog_data=data, set prog_we=1 and enter WRITE.
REQ-025 In IDLE with the FIFO non-empty, prog_mask SHALL be 2'b10 for even offset and 2'b01 for odd offset; when SWAB=1 the two values SHALL be swapped.
REQ-026 In WRITE, prog_addr, prog_data, prog_mask and prog_we SHALL stay stable until an edge with prog_rdy=1.
REQ-027 At an edge in WRITE with prog_rdy=1, the FSM SHALL clear prog_we and return to IDLE; prog_we is therefore low for at least one cycle between writes.
REQ-028 prog_rdy SHALL be ignored in IDLE.
REQ-029 From an empty FIFO in IDLE, with ioctl_wr sampled at edge N, prog_we SHALL rise at edge N+1.
REQ-030 The falling edge of downloading SHALL NOT abort queued or in-flight writes; the FIFO SHALL drain normally.
REQ-031 dwnld_busy SHALL be 1 while downloading=1, the FIFO is non-empty, or the FSM is in WRITE.
REQ-032 After the REQ-031 condition falls, dwnld_busy SHALL stay 1 for HOLD more cycles; any renewed activity SHALL reload the counter.

Reset
REQ-033 While rst_n=0, all outputs SHALL be 0 except prog_mask=2'b11, the FSM SHALL be in IDLE, and FIFO pointers, hold counter and overflow SHALL be cleared.
REQ-034 A reset asserted mid-write SHALL discard all queued bytes and the in-flight write.
REQ-035 Reset release SHALL be synchronised internally; outputs SHALL change no earlier than the first edge after rst_n rises.

Structure
REQ-036 The state encoding and the FIFO depth constant SHALL live in the shared package jtframe_dwnld_pkg.
REQ-037 The FIFO SHALL be the sub-module jtframe_ioctl_fifo (depth 4, width 25+8, full/empty flags).

Verification
REQ-038 HEADER=0, prog_rdy tied to 1: bytes 0x11, 0x22 at addr 0, 1 -> writes (addr 0, mask 10, data 11) then (addr 0, mask 01, data 22); prog_we low between them.
REQ-039 HEADER=2: bytes at addr 0..3 -> exactly two writes, both at prog_addr 0; addr 0 and 1 discarded.
REQ-040 prog_rdy held 0 while 6 bytes arrive back-to-back -> 1 write in flight plus 4 queued; the 6th byte is dropped; overflow=1; it clears on the next downloading rise.
REQ-041 downloading falls with 3 bytes queued -> all 3 written; dwnld_busy falls exactly HOLD cycles after the last prog_rdy.
REQ-042 rst_n pulsed low during WRITE -> prog_we=0 immediately; no later writes occur from the old data.
REQ-043 SDRAMW=4, offset 0x40 -> prog_addr wraps to 0x0.
